// File: rtl/control_unit.sv
// Multi-cycle Moore control FSM: walks each instruction through FETCH/DECODE/execute/writeback
// and drives the datapath strobes, mux selects and a completed-instruction counter.
module control_unit #(
  parameter int STATE_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [5:0]             i_opcode,
  output logic                   o_pc_write,
  output logic                   o_pc_write_cond,
  output logic                   o_mem_write,
  output logic                   o_mem_addr,
  output logic                   o_ir_write,
  output logic                   o_alu_src_a,
  output logic                   o_reg_read,
  output logic                   o_reg_write,
  output logic [1:0]             o_pc_source,
  output logic [1:0]             o_alu_src_b,
  output logic [1:0]             o_mem_to_reg,
  output logic [1:0]             o_branch_cond,
  output logic [2:0]             o_alu_select,
  output logic                   o_halted,
  output logic                   o_illegal_op,
  output logic [15:0]            o_instr_count,
  output logic [STATE_WIDTH-1:0] o_state
);
  // state    | meaning
  // FETCH    | 0  load IR, PC <= PC + 4
  // DECODE   | 1  read registers, precompute branch target, dispatch on opcode
  // EXEC_R   | 2  register-register ALU op
  // EXEC_I   | 3  register-immediate ALU op
  // ALU_WB   | 4  write ALU result
  // LI_WB    | 5  write immediate
  // LUI_WB   | 6  write upper immediate
  // LOAD_MEM | 7  memory read
  // LOAD_WB  | 8  write memory data
  // STORE    | 9  memory write
  // BRANCH   | 10 compare and conditionally load branch target
  // JUMP     | 11 load jump target
  // HALT     | 12 parked until reset
  typedef enum logic [STATE_WIDTH-1:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_LI_WB, S_LUI_WB,
    S_LOAD_MEM, S_LOAD_WB, S_STORE, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_NOP  = 6'h00, OP_ADD  = 6'h01, OP_NOT  = 6'h06;
  localparam logic [5:0] OP_ADDI = 6'h11, OP_SUBI = 6'h12, OP_ORI  = 6'h14;
  localparam logic [5:0] OP_LI   = 6'h20, OP_LUI  = 6'h21, OP_LW   = 6'h22, OP_SW = 6'h23;
  localparam logic [5:0] OP_BNE  = 6'h30, OP_BLE  = 6'h33, OP_JMP  = 6'h3E, OP_HALT = 6'h3F;

  state_t      r_state;
  state_t      w_next;
  state_t      w_cur;
  state_t      w_dispatch;
  logic        w_op_legal;
  logic [5:0]  r_op;
  logic [15:0] r_instr_count;
  logic [2:0]  w_alu_op;

  // Reset overrides the visible state so outputs read as FETCH for the whole reset cycle.
  assign w_cur         = i_reset ? S_FETCH : r_state;
  assign w_alu_op      = r_op[2:0] - 3'd1;
  assign o_state       = w_cur;
  assign o_instr_count = r_instr_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_FETCH;
      r_op          <= OP_NOP;
      r_instr_count <= 16'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= i_opcode;
      if (r_state != S_FETCH && w_next == S_FETCH) r_instr_count <= r_instr_count + 16'd1;
    end
  end

  always_comb begin
    w_dispatch = S_FETCH;
    w_op_legal = 1'b1;
    if (i_opcode >= OP_ADD && i_opcode <= OP_NOT)        w_dispatch = S_EXEC_R;
    else if (i_opcode >= OP_ADDI && i_opcode <= OP_ORI)  w_dispatch = S_EXEC_I;
    else if (i_opcode == OP_LI)                          w_dispatch = S_LI_WB;
    else if (i_opcode == OP_LUI)                         w_dispatch = S_LUI_WB;
    else if (i_opcode == OP_LW)                          w_dispatch = S_LOAD_MEM;
    else if (i_opcode == OP_SW)                          w_dispatch = S_STORE;
    else if (i_opcode >= OP_BNE && i_opcode <= OP_BLE)   w_dispatch = S_BRANCH;
    else if (i_opcode == OP_JMP)                         w_dispatch = S_JUMP;
    else if (i_opcode == OP_HALT)                        w_dispatch = S_HALT;
    else if (i_opcode != OP_NOP)                         w_op_legal = 1'b0;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:             w_next = S_DECODE;
      S_DECODE:            w_next = w_dispatch;
      S_EXEC_R, S_EXEC_I:  w_next = S_ALU_WB;
      S_LOAD_MEM:          w_next = S_LOAD_WB;
      S_HALT:              w_next = S_HALT;
      default:             w_next = S_FETCH;
    endcase
  end

  always_comb begin
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_mem_write     = 1'b0;
    o_mem_addr      = 1'b0;
    o_ir_write      = 1'b0;
    o_alu_src_a     = 1'b0;
    o_reg_read      = 1'b0;
    o_reg_write     = 1'b0;
    o_pc_source     = 2'b00;
    o_alu_src_b     = 2'b00;
    o_mem_to_reg    = 2'b00;
    o_branch_cond   = 2'b00;
    o_alu_select    = 3'b000;
    o_halted        = 1'b0;
    o_illegal_op    = 1'b0;
    case (w_cur)
      S_FETCH: begin
        o_ir_write  = 1'b1;
        o_pc_write  = 1'b1;
        o_alu_src_b = 2'b01;
      end
      S_DECODE: begin
        o_reg_read   = 1'b1;
        o_alu_src_b  = 2'b10;
        o_illegal_op = ~w_op_legal;
      end
      S_EXEC_R: begin
        o_alu_src_a  = 1'b1;
        o_alu_select = w_alu_op;
      end
      S_EXEC_I: begin
        o_alu_src_a  = 1'b1;
        o_alu_select = w_alu_op;
        // sign-extended immediates for add/sub, zero-extended for logic ops
        o_alu_src_b  = (r_op == OP_ADDI || r_op == OP_SUBI) ? 2'b10 : 2'b11;
      end
      S_ALU_WB:  o_reg_write = 1'b1;
      S_LI_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 2'b01;
      end
      S_LUI_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 2'b11;
      end
      S_LOAD_MEM: o_mem_addr = 1'b1;
      S_LOAD_WB: begin
        o_mem_addr   = 1'b1;
        o_mem_to_reg = 2'b10;
        o_reg_write  = 1'b1;
      end
      S_STORE: begin
        o_mem_addr  = 1'b1;
        o_mem_write = 1'b1;
        o_reg_read  = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a     = 1'b1;
        o_alu_select    = 3'b001;
        o_reg_read      = 1'b1;
        o_pc_write_cond = 1'b1;
        o_pc_source     = 2'b01;
        o_branch_cond   = r_op[1:0];
      end
      S_JUMP: begin
        o_pc_write  = 1'b1;
        o_pc_source = 2'b10;
      end
      S_HALT:  o_halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver queues the expected state/count per cycle,
// the monitor pops one entry each falling edge and checks every output against the state table.
module tb_control_unit;
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3, ALU_WB = 4'd4,
                         LI_WB = 4'd5, LUI_WB = 4'd6, LOAD_MEM = 4'd7, LOAD_WB = 4'd8, STORE = 4'd9,
                         BRANCH = 4'd10, JUMP = 4'd11, HALT = 4'd12;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [5:0]  i_opcode = 6'h00;
  logic        o_pc_write, o_pc_write_cond, o_mem_write, o_mem_addr, o_ir_write, o_alu_src_a;
  logic        o_reg_read, o_reg_write, o_halted, o_illegal_op;
  logic [1:0]  o_pc_source, o_alu_src_b, o_mem_to_reg, o_branch_cond;
  logic [2:0]  o_alu_select;
  logic [15:0] o_instr_count;
  logic [3:0]  o_state;

  always #5 clk = ~clk;

  control_unit #(.STATE_WIDTH(4)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_opcode(i_opcode),
    .o_pc_write(o_pc_write), .o_pc_write_cond(o_pc_write_cond), .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr), .o_ir_write(o_ir_write), .o_alu_src_a(o_alu_src_a),
    .o_reg_read(o_reg_read), .o_reg_write(o_reg_write), .o_pc_source(o_pc_source),
    .o_alu_src_b(o_alu_src_b), .o_mem_to_reg(o_mem_to_reg), .o_branch_cond(o_branch_cond),
    .o_alu_select(o_alu_select), .o_halted(o_halted), .o_illegal_op(o_illegal_op),
    .o_instr_count(o_instr_count), .o_state(o_state)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [5:0]  op;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          passed = 0;
  logic [15:0] m_count = 16'd0;
  logic [20:0] w_act;
  logic [20:0] w_exp;

  assign w_act = {o_pc_write, o_pc_write_cond, o_mem_write, o_mem_addr, o_ir_write, o_alu_src_a,
                  o_reg_read, o_reg_write, o_pc_source, o_alu_src_b, o_mem_to_reg, o_branch_cond,
                  o_alu_select, o_halted, o_illegal_op};

  function automatic logic [2:0] alu_of(input logic [5:0] op);
    case (op)
      6'h01, 6'h11: return 3'b000;
      6'h02, 6'h12: return 3'b001;
      6'h03, 6'h13: return 3'b010;
      6'h04, 6'h14: return 3'b011;
      6'h05:        return 3'b100;
      6'h06:        return 3'b101;
      default:      return 3'b000;
    endcase
  endfunction

  function automatic logic mapped(input logic [5:0] op);
    case (op)
      6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h11, 6'h12, 6'h13, 6'h14,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h30, 6'h31, 6'h32, 6'h33, 6'h3E, 6'h3F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected outputs straight from the per-state output table.
  function automatic logic [20:0] spec_out(input logic [3:0] st, input logic [5:0] op);
    logic pcw, pcwc, mw, ma, irw, asa, rr, rw, hlt, ill;
    logic [1:0] pcs, asb, mtr, bc;
    logic [2:0] alu;
    {pcw, pcwc, mw, ma, irw, asa, rr, rw, hlt, ill} = '0;
    {pcs, asb, mtr, bc} = '0;
    alu = 3'b000;
    case (st)
      FETCH:    begin irw = 1; pcw = 1; asb = 2'b01; end
      DECODE:   begin rr = 1; asb = 2'b10; ill = ~mapped(op); end
      EXEC_R:   begin asa = 1; alu = alu_of(op); end
      EXEC_I:   begin asa = 1; alu = alu_of(op); asb = (op == 6'h11 || op == 6'h12) ? 2'b10 : 2'b11; end
      ALU_WB:   rw = 1;
      LI_WB:    begin rw = 1; mtr = 2'b01; end
      LUI_WB:   begin rw = 1; mtr = 2'b11; end
      LOAD_MEM: ma = 1;
      LOAD_WB:  begin ma = 1; mtr = 2'b10; rw = 1; end
      STORE:    begin ma = 1; mw = 1; rr = 1; end
      BRANCH:   begin asa = 1; alu = 3'b001; rr = 1; pcwc = 1; pcs = 2'b01; bc = op[1:0]; end
      JUMP:     begin pcw = 1; pcs = 2'b10; end
      HALT:     hlt = 1;
      default:  ;
    endcase
    return {pcw, pcwc, mw, ma, irw, asa, rr, rw, pcs, asb, mtr, bc, alu, hlt, ill};
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      e = sb.pop_front();
      w_exp = spec_out(e.st, e.op);
      checks++;
      if (o_state === e.st && w_act === w_exp && o_instr_count === e.cnt)
        passed++;
      else
        $display("FAIL cycle_check t=%0t op=%h: got state=%0d outs=%h cnt=%h, want state=%0d outs=%h cnt=%h",
                 $time, e.op, o_state, w_act, o_instr_count, e.st, w_exp, e.cnt);
    end
  end

  task automatic push(input logic [3:0] st, input logic [5:0] op);
    sb.push_back('{st: st, op: op, cnt: m_count});
  endtask

  function automatic logic [15:0] sq(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return {4'd0, c, b, a};
  endfunction

  // Entered during a FETCH cycle; steps through n states after it, optionally back into FETCH.
  // Opcode carries the real value only during DECODE and is scrambled everywhere else.
  task automatic exec(input logic [5:0] op, input logic [15:0] seq, input int n, input bit to_fetch);
    logic [3:0] s;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s = seq[i*4 +: 4];
      i_opcode = (s == DECODE) ? op : 6'($urandom);
      push(s, op);
    end
    if (to_fetch) begin
      @(posedge clk); #1;
      i_opcode = 6'($urandom);
      m_count++;
      push(FETCH, op);
    end
  endtask

  // Reset high for n cycles, then released; ends in a FETCH cycle with the count cleared.
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_reset = 1'b1;
      i_opcode = 6'($urandom);
      push(FETCH, 6'h00);
      m_count = 16'd0;
    end
    @(posedge clk); #1;
    i_reset = 1'b0;
    push(FETCH, 6'h00);
  endtask

  initial begin
    @(posedge clk);
    do_reset(3);
    for (int op = 1; op <= 6; op++) exec(6'(op), sq(DECODE, EXEC_R, ALU_WB), 3, 1);
    for (int op = 'h11; op <= 'h14; op++) exec(6'(op), sq(DECODE, EXEC_I, ALU_WB), 3, 1);
    exec(6'h20, sq(DECODE, LI_WB, FETCH), 2, 1);
    exec(6'h21, sq(DECODE, LUI_WB, FETCH), 2, 1);
    exec(6'h22, sq(DECODE, LOAD_MEM, LOAD_WB), 3, 1);
    exec(6'h23, sq(DECODE, STORE, FETCH), 2, 1);
    for (int op = 'h30; op <= 'h33; op++) exec(6'(op), sq(DECODE, BRANCH, FETCH), 2, 1);
    exec(6'h3E, sq(DECODE, JUMP, FETCH), 2, 1);
    exec(6'h00, sq(DECODE, FETCH, FETCH), 1, 1);
    exec(6'h2A, sq(DECODE, FETCH, FETCH), 1, 1);
    exec(6'h07, sq(DECODE, FETCH, FETCH), 1, 1);
    exec(6'h3D, sq(DECODE, FETCH, FETCH), 1, 1);
    // reset while the load is in LOAD_MEM
    exec(6'h22, sq(DECODE, FETCH, FETCH), 1, 0);
    do_reset(1);
    exec(6'h01, sq(DECODE, EXEC_R, ALU_WB), 3, 1);
    exec(6'h3F, sq(DECODE, HALT, FETCH), 2, 0);
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      i_opcode = 6'($urandom);
      push(HALT, 6'h3F);
    end
    do_reset(1);
    for (int i = 0; i < 10; i++) exec(6'h00, sq(DECODE, FETCH, FETCH), 1, 1);
    // preload the counter just below the top so the wrap costs two NOPs instead of 65536
    dut.r_instr_count = 16'hFFFE;
    m_count = 16'hFFFE;
    sb[sb.size()-1].cnt = m_count;
    exec(6'h00, sq(DECODE, FETCH, FETCH), 1, 1);
    exec(6'h00, sq(DECODE, FETCH, FETCH), 1, 1);
    @(negedge clk); #1;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter STATE_WIDTH, default 4, giving the width of the state register and of the State output.
REQ-002 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Opcode  input  6  instruction opcode from the instruction register.
REQ-005 PCWrite, PCWriteCond, MemWrite, MemAddr, IRWrite, ALUSrcA, RegRead, RegWrite  output  1 each  datapath strobes and selects.
REQ-006 PCSource, ALUSrcB, MemtoReg, BranchCond  output  2 each  datapath mux selects.
REQ-007 ALUSelect  output  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT.
REQ-008 Halted  output  1  high while in HALT.
REQ-009 IllegalOp  output  1  one-cycle pulse in DECODE when the opcode is unmapped.
REQ-010 InstrCount  output  16  count of completed instructions.
REQ-011 State  output  STATE_WIDTH  current state, for debug.

Function
REQ-012 Opcode map SHALL be:
- R-type, R1<-R2 op R3: 0x01 ADD, 0x02 SUB, 0x03 AND, 0x04 OR, 0x05 XOR, 0x06 NOT.
- Immediate: 0x11 ADDI (SE16), 0x12 SUBI (SE16), 0x13 ANDI (ZE16), 0x14 ORI (ZE16).
- Load/store: 0x20 LI, 0x21 LUI, 0x22 LW, 0x23 SW.
- Branch: 0x30 BNE, 0x31 BEQ, 0x32 BLT, 0x33 BLE.
- Control: 0x3E JMP, 0x3F HALT, 0x00 NOP.
REQ-013 Moore FSM with states FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, LI_WB, LUI_WB, LOAD_MEM, LOAD_WB, STORE, BRANCH, JUMP, HALT; every output not listed for a state SHALL be 0.
REQ-014 FETCH: IRWrite=1, PCWrite=1, PCSource=00, ALUSrcA=0, ALUSrcB=01, ALUSelect=ADD; next state DECODE.
REQ-015 DECODE: RegRead=1, ALUSrcA=0, ALUSrcB=10, ALUSelect=ADD, which precomputes the branch target.
- Next state: R-type->EXEC_R, immediate->EXEC_I, LI->LI_WB, LUI->LUI_WB, LW->LOAD_MEM, SW->STORE, branch->BRANCH, JMP->JUMP, HALT->HALT.
- NOP and unmapped opcodes -> FETCH.
REQ-016 EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUSelect per opcode; next state ALU_WB.
REQ-017 EXEC_I: ALUSrcA=1, ALUSelect per opcode; ALUSrcB=10 for ADDI/SUBI, 11 for ANDI/ORI; next state ALU_WB.
REQ-018 ALU_WB: RegWrite=1, MemtoReg=00; next state FETCH.
REQ-019 LI_WB: RegWrite=1, MemtoReg=01; next state FETCH.
REQ-020 LUI_WB: RegWrite=1, MemtoReg=11; next state FETCH.
REQ-021 LOAD_MEM: MemAddr=1; next state LOAD_WB.
REQ-022 LOAD_WB: MemAddr=1, MemtoReg=10, RegWrite=1; next state FETCH.
REQ-023 STORE: MemAddr=1, MemWrite=1, RegRead=1; next state FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUSelect=SUB, RegRead=1, PCWriteCond=1, PCSource=01, BranchCond=Opcode[1:0]; next state FETCH.
REQ-025 JUMP: PCWrite=1, PCSource=10; next state FETCH.
REQ-026 HALT: Halted=1, all other outputs 0; the FSM SHALL stay in HALT until Reset.
REQ-027 Cycles per instruction, FETCH inclusive:
- NOP/illegal 2.
- LI, LUI, SW, branch, JMP 3.
- R-type, immediate, LW 4.
REQ-028 InstrCount SHALL increment by 1, wrapping 0xFFFF->0x0000, on every transition into FETCH from a non-FETCH state, including NOP and illegal opcodes.
REQ-029 PCWrite and RegWrite SHALL never both be 1 in the same cycle; MemWrite SHALL be 1 only in STORE.
REQ-030 Opcode SHALL be sampled only in DECODE; Opcode changes in other states SHALL have no effect.

Reset
REQ-031 Reset=1 at any clock edge, in any state including HALT or mid-instruction, SHALL force FETCH, InstrCount=0 and IllegalOp=0 on that edge.
REQ-032 While Reset=1, the outputs SHALL be the FETCH values of REQ-014, with State equal to the FETCH encoding 0.

Verification
REQ-033 Release Reset, Opcode=0x01 -> states FETCH, DECODE, EXEC_R, ALU_WB, FETCH; RegWrite=1 only in ALU_WB; InstrCount=1.
REQ-034 Opcode=0x22 -> MemAddr=1 for 2 cycles; MemtoReg=10 with RegWrite=1 in the 4th cycle; Opcode=0x23 -> MemWrite=1 exactly once, in the 3rd cycle.
REQ-035 Opcode=0x32 -> BRANCH with PCWriteCond=1, BranchCond=10, PCSource=01, ALUSelect=001.
REQ-036 Opcode=0x2A -> IllegalOp pulses 1 cycle in DECODE, FSM returns to FETCH, InstrCount increments.
REQ-037 Opcode=0x3F -> Halted=1 held for 20 cycles with every strobe 0; Reset pulsed in LOAD_MEM and in HALT -> FETCH and InstrCount=0 on the next edge.
REQ-038 0xFFFF NOPs executed -> InstrCount=0xFFFF; one more -> 0x0000.
